instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Consumer side of the pc interface: takes instr_address from pc, fetches the word from instruction
//  memory over a req/ack handshake, buffers it in a 2-entry queue for the decoder, and drives the
//  stall (fetch_halt -> pc.halt) so pc advances only when a fetched word is accepted.
//  flush (= pc_load_imm_ctrl | pc_load_alu_ctrl) discards queued and in-flight fetches.
// PARAMETERS
//  ADDR_W  32  width of instruction address / instr_pc
//  DATA_W  32  width of instruction word
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       reset, asynchronous, active-high
//  instr_address in   ADDR_W  current PC from pc
//  flush         in   1       redirect; pc loads a new address on this same edge
//  fetch_halt    out  1       to pc.halt; 0 = pc increments this edge
//  imem_req      out  1       memory request, held until imem_ack
//  imem_addr     out  ADDR_W  request address, registered, stable while imem_req=1
//  imem_ack      in   1       1-cycle response strobe; imem_rdata valid this cycle
//  imem_rdata    in   DATA_W  fetched word
//  instr_valid   out  1       queue head valid
//  instr_data    out  DATA_W  queue head word
//  instr_pc      out  ADDR_W  address of queue head word
//  instr_ready   in   1       decoder accepts head when instr_valid & instr_ready
// BEHAVIOUR
//  Reset (async): state=IDLE, count=0, imem_req=0, imem_addr=0, instr_valid=0, instr_data=0,
//   instr_pc=0, fetch_halt=1. imem_req drops without a clock edge; memory tolerates abandoned request.
//  FSM: IDLE, REQ, DRAIN. At most one request outstanding; queue depth 2 (count 0..2).
//  IDLE: if !flush and count<2 -> imem_addr<=instr_address, imem_req<=1, go REQ. Else stay.
//  REQ: imem_req=1, imem_addr held.
//   imem_ack & !flush -> push {imem_rdata, imem_addr}; fetch_halt=0 this cycle only; imem_req<=0; IDLE.
//   imem_ack & flush  -> discard data, fetch_halt=1, imem_req<=0, IDLE.
//   !imem_ack & flush -> DRAIN (imem_req stays 1, addr held: handshake is never abandoned).
//  DRAIN: imem_req=1; on imem_ack discard data, imem_req<=0, IDLE. flush ignored except queue clear.
//  fetch_halt=1 in every cycle except an accepted ack in REQ (combinational from state/imem_ack/flush).
//  Queue: instr_valid = count!=0. Pop when instr_valid & instr_ready. Push and pop in same cycle:
//   count unchanged, ordering preserved. Push never meets count=2 (issue requires count<2, one
//   outstanding). flush clears queue (count<=0) and overrides a same-cycle pop or push.
//  Throughput: one word per (memory latency + 2) cycles minimum; no back-to-back requests.
//  Addresses are word addresses; no width conversion; instr_pc = address the word was fetched from.
// TESTING
//  1 Reset: rst=1 mid-cycle -> imem_req=0, instr_valid=0, fetch_halt=1 immediately; release with
//    instr_address=0 -> next edge imem_req=1, imem_addr=0.
//  2 Single fetch: ack 3 cycles after req, rdata=0xDEADBEEF -> fetch_halt=0 for exactly that cycle;
//    next cycle instr_valid=1, instr_data=0xDEADBEEF, instr_pc=0, instr_address=1.
//  3 Backpressure: instr_ready=0, fetch addr 0,1 -> count=2, imem_req stays 0; ready=1 -> heads
//    0 then 1 popped on consecutive cycles, request for addr 2 issued after count<2.
//  4 Flush in REQ: req addr 5 pending, flush with pc loading 0x40 -> DRAIN, imem_req held with addr 5,
//    ack discarded, queue empty, fetch_halt=1 throughout; then req with imem_addr=0x40.
//  5 Flush coincident with ack: ack for addr 7 and flush same cycle -> word dropped, fetch_halt=1,
//    instr_valid=0 next cycle, next request uses loaded address.
//  6 Push+pop same cycle at count=1 with ready=1 -> count stays 1, head advances to new word, order ok.

Source files
------------

// File: rtl/instr_fetch_if.sv
// Bus bundle between the fetch unit, instruction memory and the decoder.
//   imem_req/imem_addr   fetch -> memory, request held until imem_ack
//   imem_ack/imem_rdata  memory -> fetch, single-cycle response strobe
//   instr_valid/data/pc  fetch -> decoder, queue head
//   instr_ready          decoder -> fetch, head accepted when valid & ready
// master = fetch unit side, slave = memory/decoder side.
interface instr_fetch_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_data;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr_data, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: takes the PC, fetches one word at a time from
// instruction memory over a req/ack handshake, buffers it in a 2-entry
// queue for the decoder and stalls the PC until a fetched word is accepted.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   instr_address   current PC
//   flush           redirect; PC loads a new address on this edge
//   fetch_halt      PC stall (0 = PC increments this edge), combinational
//   bus             memory and decoder signals (instr_fetch_if.master)
module instr_fetch #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] instr_address,
  input  logic              flush,
  output logic              fetch_halt,
  instr_fetch_if.master     bus
);

  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] QUEUE_DEPTH = CNT_W'(2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] head_data_q, head_data_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic [DATA_W-1:0] tail_data_q, tail_data_d;
  logic [ADDR_W-1:0] tail_pc_q, tail_pc_d;
  logic              push;
  logic              pop;

  // Request FSM: one outstanding request, never abandoned once issued.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    push       = 1'b0;
    fetch_halt = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (!flush && (count_q < QUEUE_DEPTH)) begin
          addr_d  = instr_address;
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
          if (!flush) begin
            push       = 1'b1;
            fetch_halt = 1'b0;
          end
        end else if (flush) begin
          // Redirect mid-request: wait out the ack, then drop the word.
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (bus.imem_ack) begin
          req_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign pop = valid_q & bus.instr_ready;

  // Two-entry queue held as head + tail registers; flush wins over push/pop.
  always_comb begin
    count_d     = count_q;
    head_data_d = head_data_q;
    head_pc_d   = head_pc_q;
    tail_data_d = tail_data_q;
    tail_pc_d   = tail_pc_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          count_d = count_q + CNT_W'(1);
          if (count_q == '0) begin
            head_data_d = bus.imem_rdata;
            head_pc_d   = addr_q;
          end else begin
            tail_data_d = bus.imem_rdata;
            tail_pc_d   = addr_q;
          end
        end
        2'b01: begin
          count_d     = count_q - CNT_W'(1);
          head_data_d = tail_data_q;
          head_pc_d   = tail_pc_q;
        end
        2'b11: begin
          // Only reachable at count 1: the new word becomes the head.
          head_data_d = bus.imem_rdata;
          head_pc_d   = addr_q;
        end
        default: ;
      endcase
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= 1'b0;
      addr_q      <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      head_data_q <= '0;
      head_pc_q   <= '0;
      tail_data_q <= '0;
      tail_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      head_data_q <= head_data_d;
      head_pc_q   <= head_pc_d;
      tail_data_q <= tail_data_d;
      tail_pc_q   <= tail_pc_d;
    end
  end

  assign bus.imem_req    = req_q;
  assign bus.imem_addr   = addr_q;
  assign bus.instr_valid = valid_q;
  assign bus.instr_data  = head_data_q;
  assign bus.instr_pc    = head_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized
// run scored against a queue-based model of the fetch/PC/decoder loop.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_address;
  logic        flush;
  logic        fetch_halt;

  instr_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  instr_fetch #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_address (instr_address),
    .flush         (flush),
    .fetch_halt    (fetch_halt),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Observed values of the current cycle.
  logic        s_req, s_halt, s_valid;
  logic [31:0] s_addr, s_data, s_pc, s_ia;
  // Model expectations for the current cycle.
  logic        e_halt, e_valid, e_next_req;
  logic [63:0] e_head;
  // Model state: queued {data, pc}, PC, and "current request was redirected".
  logic [63:0] exp_q[$];
  logic [31:0] pc;
  logic        dirty;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h5A5A} + 32'h1357_9BDF;
  endfunction

  task automatic do_reset(input logic [31:0] pc0);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    flush = 1'b0;
    pc = pc0;
    instr_address = pc0;
    exp_q.delete();
    dirty = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock of stimulus; records observations and advances the model.
  task automatic step(input logic ack, input logic [31:0] rd, input logic fl,
                      input logic [31:0] tgt, input logic rdy);
    logic accept;
    @(negedge clk);
    bus.imem_ack = ack;
    bus.imem_rdata = rd;
    flush = fl;
    bus.instr_ready = rdy;
    #1;
    s_req = bus.imem_req;   s_addr = bus.imem_addr;  s_halt = fetch_halt;
    s_valid = bus.instr_valid; s_data = bus.instr_data; s_pc = bus.instr_pc;
    s_ia = instr_address;
    accept = s_req && ack && !fl && !dirty;
    e_halt = !accept;
    e_valid = (exp_q.size() != 0);
    e_head = e_valid ? exp_q[0] : 64'd0;
    e_next_req = s_req ? !ack : (!fl && exp_q.size() < 2);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      dirty = s_req && !ack;
    end else begin
      if (e_valid && rdy) void'(exp_q.pop_front());
      if (accept) exp_q.push_back({rd, s_addr});
      if (s_req && ack) dirty = 1'b0;
    end
    if (fl) pc = tgt;
    else if (!s_halt) pc = pc + 32'd1;
    #1 instr_address = pc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.instr_ready = 1'b0;
    flush = 1'b0; instr_address = '0;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || fetch_halt !== 1'b1) begin
      errors++; $display("FAIL reset_initial req=%0b valid=%0b halt=%0b want 0 0 1",
                         bus.imem_req, bus.instr_valid, fetch_halt); end
    do_reset(32'd0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'd0) begin
      errors++; $display("FAIL reset_first_req req=%0b addr=%h want 1 0", s_req, s_addr); end
    step(1'b1, 32'h1111_2222, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    // Now mid-cycle with a queued word and a new request pending.
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0 || bus.instr_valid !== 1'b0 || fetch_halt !== 1'b1 ||
                  bus.instr_data !== 32'd0 || bus.instr_pc !== 32'd0 || bus.imem_addr !== 32'd0) begin
      errors++; $display("FAIL reset_async req=%0b valid=%0b halt=%0b data=%h pc=%h addr=%h want 0 0 1 0 0 0",
                         bus.imem_req, bus.instr_valid, fetch_halt, bus.instr_data, bus.instr_pc,
                         bus.imem_addr); end
    do_reset(32'd0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'd0) begin
      errors++; $display("FAIL reset_rerelease req=%0b addr=%h want 1 0", s_req, s_addr); end
  endtask

  task automatic test_single_fetch();
    do_reset(32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_halt !== 1'b1) begin
        errors++; $display("FAIL single_wait%0d req=%0b halt=%0b want 1 1", i, s_req, s_halt); end
    end
    step(1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
    checks++; if (s_halt !== 1'b0) begin
      errors++; $display("FAIL single_ack_halt got %0b want 0", s_halt); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_halt !== 1'b1 || s_valid !== 1'b1 || s_data !== 32'hDEAD_BEEF ||
                  s_pc !== 32'd0 || s_ia !== 32'd1 || s_req !== 1'b0) begin
      errors++; $display("FAIL single_head halt=%0b valid=%0b data=%h pc=%h ia=%h req=%0b want 1 1 deadbeef 0 1 0",
                         s_halt, s_valid, s_data, s_pc, s_ia, s_req); end
  endtask

  task automatic test_backpressure();
    do_reset(32'd0);
    for (int w = 0; w < 2; w++) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'(w)) begin
        errors++; $display("FAIL bp_req%0d req=%0b addr=%h want 1 %0d", w, s_req, s_addr, w); end
      step(1'b1, mem_word(32'(w)), 1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, '0, 1'b0);
      checks++; if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'd0) begin
        errors++; $display("FAIL bp_full%0d req=%0b valid=%0b pc=%h want 0 1 0", i, s_req, s_valid, s_pc); end
    end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'd0 || s_data !== mem_word(32'd0) || s_req !== 1'b0) begin
      errors++; $display("FAIL bp_pop0 valid=%0b pc=%h data=%h req=%0b want 1 0 %h 0",
                         s_valid, s_pc, s_data, s_req, mem_word(32'd0)); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'd1 || s_data !== mem_word(32'd1) || s_req !== 1'b0) begin
      errors++; $display("FAIL bp_pop1 valid=%0b pc=%h data=%h req=%0b want 1 1 %h 0",
                         s_valid, s_pc, s_data, s_req, mem_word(32'd1)); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b0 || s_req !== 1'b1 || s_addr !== 32'd2) begin
      errors++; $display("FAIL bp_next_req valid=%0b req=%0b addr=%h want 0 1 2", s_valid, s_req, s_addr); end
  endtask

  task automatic test_flush_in_req();
    do_reset(32'd4);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, mem_word(32'd4), 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'd5 || s_valid !== 1'b1) begin
      errors++; $display("FAIL fr_pending req=%0b addr=%h valid=%0b want 1 5 1", s_req, s_addr, s_valid); end
    step(1'b0, '0, 1'b1, 32'h40, 1'b0);
    checks++; if (s_halt !== 1'b1) begin
      errors++; $display("FAIL fr_flush_halt got %0b want 1", s_halt); end
    for (int i = 0; i < 2; i++) begin
      step(i == 1, 32'hBAD0_0005, 1'b0, '0, 1'b1);
      checks++; if (s_req !== 1'b1 || s_addr !== 32'd5 || s_valid !== 1'b0 || s_halt !== 1'b1 ||
                    s_ia !== 32'h40) begin
        errors++; $display("FAIL fr_drain%0d req=%0b addr=%h valid=%0b halt=%0b ia=%h want 1 5 0 1 40",
                           i, s_req, s_addr, s_valid, s_halt, s_ia); end
    end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_req !== 1'b0 || s_valid !== 1'b0) begin
      errors++; $display("FAIL fr_discard req=%0b valid=%0b want 0 0", s_req, s_valid); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h40) begin
      errors++; $display("FAIL fr_redirect req=%0b addr=%h want 1 40", s_req, s_addr); end
  endtask

  task automatic test_flush_with_ack();
    do_reset(32'd7);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'd7) begin
      errors++; $display("FAIL fa_req req=%0b addr=%h want 1 7", s_req, s_addr); end
    step(1'b1, mem_word(32'd7), 1'b1, 32'h80, 1'b1);
    checks++; if (s_halt !== 1'b1) begin
      errors++; $display("FAIL fa_halt got %0b want 1", s_halt); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_valid !== 1'b0 || s_req !== 1'b0 || s_ia !== 32'h80) begin
      errors++; $display("FAIL fa_dropped valid=%0b req=%0b ia=%h want 0 0 80", s_valid, s_req, s_ia); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h80) begin
      errors++; $display("FAIL fa_redirect req=%0b addr=%h want 1 80", s_req, s_addr); end
  endtask

  task automatic test_push_pop();
    do_reset(32'h10);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, mem_word(32'h10), 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, mem_word(32'h11), 1'b0, '0, 1'b1);
    checks++; if (s_halt !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h10) begin
      errors++; $display("FAIL pp_same_cycle halt=%0b valid=%0b pc=%h want 0 1 10", s_halt, s_valid, s_pc); end
    step(1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (s_valid !== 1'b1 || s_pc !== 32'h11 || s_data !== mem_word(32'h11)) begin
      errors++; $display("FAIL pp_head valid=%0b pc=%h data=%h want 1 11 %h",
                         s_valid, s_pc, s_data, mem_word(32'h11)); end
    step(1'b0, '0, 1'b0, '0, 1'b1);
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h12 || s_valid !== 1'b1 || s_pc !== 32'h11) begin
      errors++; $display("FAIL pp_count1 req=%0b addr=%h valid=%0b pc=%h want 1 12 1 11",
                         s_req, s_addr, s_valid, s_pc); end
    step(1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (s_valid !== 1'b0) begin
      errors++; $display("FAIL pp_empty valid=%0b want 0", s_valid); end
  endtask

  task automatic test_random();
    logic        pred_req, prev_req, ack, fl, rdy;
    logic [31:0] prev_addr, tgt;
    int          bad_before;
    do_reset($urandom);
    pred_req = 1'b1;
    prev_req = 1'b0;
    prev_addr = '0;
    for (int c = 0; c < 3000; c++) begin
      ack = bus.imem_req && ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 19) == 0);
      tgt = $urandom;
      rdy = ($urandom_range(0, 3) != 0);
      if (c % 500 < 60) rdy = 1'b0;
      bad_before = errors;
      step(ack, $urandom, fl, tgt, rdy);
      checks++; if (s_halt !== e_halt) begin
        errors++; $display("FAIL rnd_halt cyc=%0d got %0b want %0b", c, s_halt, e_halt); end
      checks++; if (s_valid !== e_valid) begin
        errors++; $display("FAIL rnd_valid cyc=%0d got %0b want %0b", c, s_valid, e_valid); end
      if (e_valid) begin
        checks++; if ({s_data, s_pc} !== e_head) begin
          errors++; $display("FAIL rnd_head cyc=%0d got %h/%h want %h/%h", c, s_data, s_pc,
                             e_head[63:32], e_head[31:0]); end
      end
      checks++; if (s_req !== pred_req) begin
        errors++; $display("FAIL rnd_req cyc=%0d got %0b want %0b", c, s_req, pred_req); end
      if (s_req && prev_req) begin
        checks++; if (s_addr !== prev_addr) begin
          errors++; $display("FAIL rnd_addr_hold cyc=%0d got %h want %h", c, s_addr, prev_addr); end
      end else if (s_req) begin
        checks++; if (s_addr !== s_ia) begin
          errors++; $display("FAIL rnd_issue_addr cyc=%0d got %h want %h", c, s_addr, s_ia); end
      end
      pred_req = e_next_req;
      prev_req = s_req && !ack;
      prev_addr = s_addr;
      if (errors - bad_before > 0 && errors > 20) break;
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_backpressure();
    test_flush_in_req();
    test_flush_with_ack();
    test_push_pop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
